// File: rtl/ir_nec_pkg.sv
// Shared NEC receiver definitions: FSM states, 50 MHz timing defaults,
// the key codes understood by the ALU keypad front end, and small helpers.
package ir_nec_pkg;

  localparam int CNT_W = 20;

  localparam int LEAD_MARK_MIN_DEF  = 400000;
  localparam int LEAD_MARK_MAX_DEF  = 500000;
  localparam int LEAD_SPACE_MIN_DEF = 180000;
  localparam int LEAD_SPACE_MAX_DEF = 270000;
  localparam int REP_SPACE_MIN_DEF  = 90000;
  localparam int REP_SPACE_MAX_DEF  = 140000;
  localparam int BIT_MARK_MIN_DEF   = 20000;
  localparam int BIT_MARK_MAX_DEF   = 40000;
  localparam int ZERO_MIN_DEF       = 20000;
  localparam int ZERO_MAX_DEF       = 42000;
  localparam int ONE_MIN_DEF        = 70000;
  localparam int ONE_MAX_DEF        = 100000;
  localparam int VALID_CYCLES_DEF   = 50000;

  localparam logic [7:0] KEY_ON_OFF = 8'd18;
  localparam logic [7:0] KEY_DEF_A  = 8'd15;
  localparam logic [7:0] KEY_DEF_B  = 8'd19;
  localparam logic [7:0] KEY_CLEAR  = 8'd16;
  localparam logic [7:0] KEY_SIGN   = 8'd12;
  localparam logic [7:0] KEY_SUM    = 8'd26;
  localparam logic [7:0] KEY_MINUS  = 8'd30;
  localparam logic [7:0] KEY_DIGIT_MAX = 8'd9;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    CHECK,
    ERR
  } nec_state_e;

  // Inclusive window test on a duration count.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // A received word is good when both upper bytes are inverses of the lower ones.
  function automatic logic nec_frame_ok(input logic [31:0] w);
    return (w[31:24] == ~w[23:16]) && (w[15:8] == ~w[7:0]);
  endfunction

  // Digit keys occupy codes 0..9.
  function automatic logic key_is_digit(input logic [7:0] k);
    return k <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/ir_nec_keycode_tx_pulse.sv
// Fixed-width validate pulse generator; a start while busy is ignored.
module ir_pulse_stretch
  import ir_nec_pkg::*;
#(
  parameter int VALID_CYCLES = VALID_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam int W = (VALID_CYCLES > 1) ? $clog2(VALID_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(VALID_CYCLES - 1);

  logic         busy_d, busy_q;
  logic [W-1:0] cnt_d, cnt_q;

  // Load the down-counter on start, drop busy after the last counted cycle.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (busy_q) begin
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = LAST;
    end
  end

  // Pulse state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/ir_nec_keycode_tx.sv
// NEC IR frame decoder producing ALU key codes on a data/validate handshake.
module ir_nec_keycode_tx
  import ir_nec_pkg::*;
#(
  parameter int LEAD_MARK_MIN  = LEAD_MARK_MIN_DEF,
  parameter int LEAD_MARK_MAX  = LEAD_MARK_MAX_DEF,
  parameter int LEAD_SPACE_MIN = LEAD_SPACE_MIN_DEF,
  parameter int LEAD_SPACE_MAX = LEAD_SPACE_MAX_DEF,
  parameter int REP_SPACE_MIN  = REP_SPACE_MIN_DEF,
  parameter int REP_SPACE_MAX  = REP_SPACE_MAX_DEF,
  parameter int BIT_MARK_MIN   = BIT_MARK_MIN_DEF,
  parameter int BIT_MARK_MAX   = BIT_MARK_MAX_DEF,
  parameter int ZERO_MIN       = ZERO_MIN_DEF,
  parameter int ZERO_MAX       = ZERO_MAX_DEF,
  parameter int ONE_MIN        = ONE_MIN_DEF,
  parameter int ONE_MAX        = ONE_MAX_DEF,
  parameter int VALID_CYCLES   = VALID_CYCLES_DEF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       IRDA_RXD,
  output logic [7:0] data,
  output logic [7:0] address,
  output logic       validate,
  output logic       frame_err
);

  localparam logic [CNT_W-1:0] LM_MIN = CNT_W'(LEAD_MARK_MIN);
  localparam logic [CNT_W-1:0] LM_MAX = CNT_W'(LEAD_MARK_MAX);
  localparam logic [CNT_W-1:0] LS_MIN = CNT_W'(LEAD_SPACE_MIN);
  localparam logic [CNT_W-1:0] LS_MAX = CNT_W'(LEAD_SPACE_MAX);
  localparam logic [CNT_W-1:0] RS_MIN = CNT_W'(REP_SPACE_MIN);
  localparam logic [CNT_W-1:0] RS_MAX = CNT_W'(REP_SPACE_MAX);
  localparam logic [CNT_W-1:0] BM_MIN = CNT_W'(BIT_MARK_MIN);
  localparam logic [CNT_W-1:0] BM_MAX = CNT_W'(BIT_MARK_MAX);
  localparam logic [CNT_W-1:0] Z_MIN  = CNT_W'(ZERO_MIN);
  localparam logic [CNT_W-1:0] Z_MAX  = CNT_W'(ZERO_MAX);
  localparam logic [CNT_W-1:0] O_MIN  = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0] O_MAX  = CNT_W'(ONE_MAX);

  nec_state_e       state_d, state_q;
  logic             ir_sync_d, ir_sync_q;
  logic             ir_s_d, ir_s_q;
  logic             ir_prev_d, ir_prev_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [5:0]       bit_cnt_d, bit_cnt_q;
  logic [31:0]      sr_d, sr_q;
  logic [7:0]       data_d, data_q;
  logic [7:0]       address_d, address_q;
  logic             load_d, load_q;
  logic             frame_err_d, frame_err_q;
  logic             pulse_busy;
  logic             ir_edge, ir_rise, ir_fall;

  assign ir_edge = ir_s_q ^ ir_prev_q;
  assign ir_rise = ir_s_q & ~ir_prev_q;
  assign ir_fall = ~ir_s_q & ir_prev_q;

  // Next-state logic: synchronizer, duration counter and the frame-walking FSM.
  always_comb begin
    ir_sync_d   = IRDA_RXD;
    ir_s_d      = ir_sync_q;
    ir_prev_d   = ir_s_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    data_d      = data_q;
    address_d   = address_q;
    load_d      = 1'b0;
    frame_err_d = 1'b0;

    if (ir_edge)           cnt_d = '0;
    else if (cnt_q != '1)  cnt_d = cnt_q + 1'b1;
    else                   cnt_d = cnt_q;

    case (state_q)
      IDLE: begin
        if (!ir_s_q) state_d = LEAD_MARK;
      end
      LEAD_MARK: begin
        if (cnt_q > LM_MAX)      state_d = ERR;
        else if (ir_rise)        state_d = (cnt_q < LM_MIN) ? IDLE : LEAD_SPACE;
      end
      LEAD_SPACE: begin
        if (ir_fall || (cnt_q > LS_MAX)) begin
          if (in_window(cnt_q, LS_MIN, LS_MAX)) begin
            state_d   = BIT_MARK;
            bit_cnt_d = '0;
          end else if (in_window(cnt_q, RS_MIN, RS_MAX)) begin
            state_d = IDLE;
          end else begin
            state_d = ERR;
          end
        end
      end
      BIT_MARK: begin
        if (cnt_q > BM_MAX) begin
          state_d = ERR;
        end else if (ir_rise) begin
          if (cnt_q < BM_MIN)             state_d = ERR;
          else if (bit_cnt_q == 6'd32)    state_d = CHECK;
          else                            state_d = BIT_SPACE;
        end
      end
      BIT_SPACE: begin
        if (cnt_q > O_MAX) begin
          state_d = ERR;
        end else if (ir_fall) begin
          if (in_window(cnt_q, Z_MIN, Z_MAX)) begin
            sr_d      = {1'b0, sr_q[31:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = BIT_MARK;
          end else if (in_window(cnt_q, O_MIN, O_MAX)) begin
            sr_d      = {1'b1, sr_q[31:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = BIT_MARK;
          end else begin
            state_d = ERR;
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (nec_frame_ok(sr_q) && !pulse_busy && !load_q) begin
          data_d    = sr_q[23:16];
          address_d = sr_q[7:0];
          load_d    = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      ERR: begin
        frame_err_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoder state and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      ir_sync_q   <= 1'b1;
      ir_s_q      <= 1'b1;
      ir_prev_q   <= 1'b1;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      address_q   <= '0;
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_sync_q   <= ir_sync_d;
      ir_s_q      <= ir_s_d;
      ir_prev_q   <= ir_prev_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      address_q   <= address_d;
      load_q      <= load_d;
      frame_err_q <= frame_err_d;
    end
  end

  ir_pulse_stretch #(
    .VALID_CYCLES(VALID_CYCLES)
  ) u_pulse (
    .clk  (CLOCK_50),
    .reset(reset),
    .start(load_q),
    .busy (pulse_busy)
  );

  assign data      = data_q;
  assign address   = address_q;
  assign validate  = pulse_busy;
  assign frame_err = frame_err_q;

endmodule
